// File: rtl/router_buffer_pkg.sv
// Shared definitions for the router input-buffer slice.
// Holds the default flit width, per-VC depth and VC count, the flit and
// VC-index typedefs built from those defaults, and the helper that sizes
// a VC index field.
package router_buffer_pkg;

    localparam int DEFAULT_BUFFER_WIDTH     = 64;
    localparam int DEFAULT_BUFFER_DEPTH_LOG = 3;
    localparam int DEFAULT_BUFFER_DEPTH     = 2 ** DEFAULT_BUFFER_DEPTH_LOG;
    localparam int DEFAULT_NUM_VC           = 4;

    // A VC index always needs at least one bit, even with a single VC.
    function automatic int vcLog(input int numVc);
        return (numVc > 1) ? $clog2(numVc) : 1;
    endfunction

    localparam int DEFAULT_VC_LOG = vcLog(DEFAULT_NUM_VC);

    typedef logic [DEFAULT_BUFFER_WIDTH-1:0] flit_t;
    typedef logic [DEFAULT_VC_LOG-1:0]       vc_idx_t;

endpackage

// File: rtl/vc_fifo_ctrl.sv
// Pointer, occupancy and status bookkeeping for one virtual channel.
// The storage itself lives in the parent; this block only decides whether
// a request is accepted and where the parent should write or read.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   i_wrReq         write request already steered to this VC
//   i_rdReq         pop request already steered to this VC
//   o_wrAccept      write accepted this cycle
//   o_rdAccept      pop accepted this cycle
//   o_wrPtr         tail slot for the next write
//   o_rdPtr         head slot currently shown
//   o_count         occupancy, 0..2**DEPTH_LOG
//   o_full, o_empty, o_almostFull  status from the registered count
module vc_fifo_ctrl
    import router_buffer_pkg::*;
#(
    parameter int DEPTH_LOG = DEFAULT_BUFFER_DEPTH_LOG,
    parameter int AF_TH     = DEFAULT_BUFFER_DEPTH - 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wrReq,
    input  logic                 i_rdReq,
    output logic                 o_wrAccept,
    output logic                 o_rdAccept,
    output logic [DEPTH_LOG-1:0] o_wrPtr,
    output logic [DEPTH_LOG-1:0] o_rdPtr,
    output logic [DEPTH_LOG:0]   o_count,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almostFull
);

    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam int CNT_W = DEPTH_LOG + 1;

    logic [DEPTH_LOG-1:0] r_wrPtr;
    logic [DEPTH_LOG-1:0] r_rdPtr;
    logic [CNT_W-1:0]     r_count;

    // The extra count bit lets all DEPTH slots be used; full/empty come
    // from the count rather than from pointer comparison.
    assign o_full       = (r_count == CNT_W'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_almostFull = (r_count >= CNT_W'(AF_TH));

    // Acceptance looks only at the registered state, so a write into a
    // full VC is refused even if the same cycle also pops it.
    assign o_wrAccept = i_wrReq && !o_full;
    assign o_rdAccept = i_rdReq && !o_empty;

    assign o_wrPtr = r_wrPtr;
    assign o_rdPtr = r_rdPtr;
    assign o_count = r_count;

    // Pointers wrap naturally at DEPTH; the count moves only when exactly
    // one of write/pop is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (o_wrAccept) begin
                r_wrPtr <= r_wrPtr + DEPTH_LOG'(1);
            end
            if (o_rdAccept) begin
                r_rdPtr <= r_rdPtr + DEPTH_LOG'(1);
            end
            case ({o_wrAccept, o_rdAccept})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vc_buffer.sv
// Multi-VC input buffer with show-ahead output.
// Each virtual channel is an independent FIFO sharing one flat storage
// array addressed as {vc, slot}. The head of the selected read VC is always
// visible on out; popping advances to the next head combinationally.
//
// Ports
//   clk, rst             clock and asynchronous active-high reset
//   in, in_vc, produce   write flit, its target VC, write request
//   rd_vc, consume       VC shown on out, pop request for that VC
//   out                  head flit of rd_vc (zero when rd_vc is empty)
//   full, empty, almost_full  per-VC status vectors
//   usedw                per-VC occupancy, VC0 in the low bits
//   overflow, underflow  sticky flags for refused writes / pops
module vc_buffer
    import router_buffer_pkg::*;
#(
    parameter int  BUFFER_WIDTH     = DEFAULT_BUFFER_WIDTH,
    parameter int  BUFFER_DEPTH_LOG = DEFAULT_BUFFER_DEPTH_LOG,
    parameter int  NUM_VC           = DEFAULT_NUM_VC,
    parameter int  ALMOST_FULL_TH   = (2 ** BUFFER_DEPTH_LOG) - 2,
    localparam int VC_LOG           = vcLog(NUM_VC)
)(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [BUFFER_WIDTH-1:0]                in,
    input  logic [VC_LOG-1:0]                      in_vc,
    input  logic                                   produce,
    input  logic [VC_LOG-1:0]                      rd_vc,
    input  logic                                   consume,
    output logic [BUFFER_WIDTH-1:0]                out,
    output logic [NUM_VC-1:0]                      full,
    output logic [NUM_VC-1:0]                      empty,
    output logic [NUM_VC-1:0]                      almost_full,
    output logic [NUM_VC*(BUFFER_DEPTH_LOG+1)-1:0] usedw,
    output logic                                   overflow,
    output logic                                   underflow
);

    localparam int BUFFER_DEPTH = 2 ** BUFFER_DEPTH_LOG;
    localparam int CNT_W        = BUFFER_DEPTH_LOG + 1;
    // Sized by the full VC index range so {vc, ptr} is always in bounds,
    // even for an out-of-range rd_vc.
    localparam int MEM_DEPTH    = (2 ** VC_LOG) * BUFFER_DEPTH;

    logic [BUFFER_WIDTH-1:0]     r_mem [MEM_DEPTH];
    logic                        r_overflow;
    logic                        r_underflow;

    logic [NUM_VC-1:0]           w_wrReq;
    logic [NUM_VC-1:0]           w_rdReq;
    logic [NUM_VC-1:0]           w_wrAccept;
    logic [NUM_VC-1:0]           w_rdAccept;
    logic [BUFFER_DEPTH_LOG-1:0] w_wrPtr [NUM_VC];
    logic [BUFFER_DEPTH_LOG-1:0] w_rdPtr [NUM_VC];
    logic [CNT_W-1:0]            w_count [NUM_VC];
    logic [BUFFER_DEPTH_LOG-1:0] w_wrPtrSel;
    logic [BUFFER_DEPTH_LOG-1:0] w_rdPtrSel;
    logic                        w_rdSelEmpty;
    logic                        w_anyWr;
    logic                        w_anyRd;

    // An index with no matching VC raises no request anywhere, so it is
    // refused and flagged exactly like a full/empty VC.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign w_wrReq[v] = produce && (in_vc == VC_LOG'(v));
        assign w_rdReq[v] = consume && (rd_vc == VC_LOG'(v));

        vc_fifo_ctrl #(
            .DEPTH_LOG (BUFFER_DEPTH_LOG),
            .AF_TH     (ALMOST_FULL_TH)
        ) u_ctrl (
            .clk          (clk),
            .rst          (rst),
            .i_wrReq      (w_wrReq[v]),
            .i_rdReq      (w_rdReq[v]),
            .o_wrAccept   (w_wrAccept[v]),
            .o_rdAccept   (w_rdAccept[v]),
            .o_wrPtr      (w_wrPtr[v]),
            .o_rdPtr      (w_rdPtr[v]),
            .o_count      (w_count[v]),
            .o_full       (full[v]),
            .o_empty      (empty[v]),
            .o_almostFull (almost_full[v])
        );

        assign usedw[v*CNT_W +: CNT_W] = w_count[v];
    end

    assign w_anyWr = |w_wrAccept;
    assign w_anyRd = |w_rdAccept;

    // Pick the tail pointer of the write VC and the head pointer of the
    // read VC; an unknown read VC is reported as empty.
    always_comb begin
        w_wrPtrSel   = '0;
        w_rdPtrSel   = '0;
        w_rdSelEmpty = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            if (in_vc == VC_LOG'(v)) begin
                w_wrPtrSel = w_wrPtr[v];
            end
            if (rd_vc == VC_LOG'(v)) begin
                w_rdPtrSel   = w_rdPtr[v];
                w_rdSelEmpty = empty[v];
            end
        end
    end

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_anyWr) begin
            r_mem[{in_vc, w_wrPtrSel}] <= in;
        end
    end

    // Forcing zero on an empty VC keeps out defined even though the
    // array powers up with unknown contents.
    assign out = w_rdSelEmpty ? '0 : r_mem[{rd_vc, w_rdPtrSel}];

    // Error flags latch on any refused request and hold until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (produce && !w_anyWr) begin
                r_overflow <= 1'b1;
            end
            if (consume && !w_anyRd) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_vc_buffer.sv
// Self-checking bench for vc_buffer with default parameters.
// A per-VC queue model is the scoreboard: accepted writes push the flit,
// accepted pops pop the expected head and compare it with out.
module tb_vc_buffer;
    import router_buffer_pkg::*;

    localparam int NVC   = 4;
    localparam int DL    = 3;
    localparam int DEPTH = 8;
    localparam int AFTH  = 6;
    localparam int CW    = DL + 1;
    localparam int W     = 64;

    logic               clk = 1'b0;
    logic               rst;
    flit_t              flitIn;
    vc_idx_t            inVc;
    logic               produce;
    vc_idx_t            rdVc;
    logic               consume;
    flit_t              flitOut;
    logic [NVC-1:0]     full;
    logic [NVC-1:0]     empty;
    logic [NVC-1:0]     almostFull;
    logic [NVC*CW-1:0]  usedw;
    logic               overflow;
    logic               underflow;

    int                 assertCount = 0;
    int                 failCount   = 0;
    flit_t              model [NVC][$];
    logic               modelOvf;
    logic               modelUnf;

    always #5 clk = ~clk;

    vc_buffer #(
        .BUFFER_WIDTH     (W),
        .BUFFER_DEPTH_LOG (DL),
        .NUM_VC           (NVC),
        .ALMOST_FULL_TH   (AFTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (flitIn),
        .in_vc       (inVc),
        .produce     (produce),
        .rd_vc       (rdVc),
        .consume     (consume),
        .out         (flitOut),
        .full        (full),
        .empty       (empty),
        .almost_full (almostFull),
        .usedw       (usedw),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Compare every status output against what the queue model implies.
    task automatic checkStatus();
        logic [NVC*CW-1:0] expUsed;
        logic [NVC-1:0]    expEmpty;
        logic [NVC-1:0]    expFull;
        logic [NVC-1:0]    expAf;
        int                n;
        for (int v = 0; v < NVC; v++) begin
            n = model[v].size();
            expUsed[v*CW +: CW] = CW'(n);
            expEmpty[v] = (n == 0);
            expFull[v]  = (n == DEPTH);
            expAf[v]    = (n >= AFTH);
        end
        checkOutput("usedw",       W'(usedw),      W'(expUsed));
        checkOutput("empty",       W'(empty),      W'(expEmpty));
        checkOutput("full",        W'(full),       W'(expFull));
        checkOutput("almost_full", W'(almostFull), W'(expAf));
        checkOutput("overflow",    W'(overflow),   W'(modelOvf));
        checkOutput("underflow",   W'(underflow),  W'(modelUnf));
    endtask

    // Drive one cycle of stimulus, check the shown head, update the
    // model, clock, then check status after the edge.
    task automatic applyStimulus(input logic prod, input vc_idx_t iv, input flit_t data,
                                 input logic cons, input vc_idx_t rv);
        logic  wrOk;
        logic  rdOk;
        flit_t exp;
        produce = prod;
        inVc    = iv;
        flitIn  = data;
        consume = cons;
        rdVc    = rv;
        #2;
        wrOk = prod && (model[iv].size() < DEPTH);
        rdOk = cons && (model[rv].size() > 0);
        if (model[rv].size() > 0) begin
            checkOutput("head", flitOut, model[rv][0]);
        end
        if (rdOk) begin
            exp = model[rv].pop_front();
        end
        if (wrOk) begin
            model[iv].push_back(data);
        end
        if (prod && !wrOk) modelOvf = 1'b1;
        if (cons && !rdOk) modelUnf = 1'b1;
        @(posedge clk);
        #1;
        produce = 1'b0;
        consume = 1'b0;
        checkStatus();
    endtask

    task automatic clearModel();
        for (int v = 0; v < NVC; v++) begin
            model[v].delete();
        end
        modelOvf = 1'b0;
        modelUnf = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        produce = 1'b0;
        consume = 1'b0;
        inVc    = '0;
        rdVc    = '0;
        flitIn  = '0;
        clearModel();
        @(posedge clk);
        #1;
        checkStatus();
        rst = 1'b0;

        // Three flits into VC1, head visible without popping.
        applyStimulus(1'b1, 2'd1, 64'h11, 1'b0, 2'd0);
        applyStimulus(1'b1, 2'd1, 64'h22, 1'b0, 2'd0);
        applyStimulus(1'b1, 2'd1, 64'h33, 1'b0, 2'd0);
        rdVc = 2'd1;
        #2;
        checkOutput("vc1Head", flitOut, 64'h11);
        checkOutput("vc1Used", W'(usedw[1*CW +: CW]), 64'd3);
        checkOutput("emptyVec", W'(empty), 64'b1101);

        // Overfill VC2; the ninth flit must be refused and never surface.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 2'd2, 64'h200 + 64'(i), 1'b0, 2'd2);
        end
        checkOutput("vc2Full", W'(full[2]), 64'd1);
        checkOutput("vc2Ovf", W'(overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 2'd0, 64'h0, 1'b1, 2'd2);
        end

        // Steady write+pop on VC0 across the pointer wrap.
        applyStimulus(1'b1, 2'd0, 64'hA0, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 2'd0, 64'hB00 + 64'(i), 1'b1, 2'd0);
            checkOutput("vc0Steady", W'(usedw[0 +: CW]), 64'd1);
        end

        // Write VC3 while draining VC0, then drain VC3.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd0, 64'hC00 + 64'(i), 1'b0, 2'd0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd3, 64'h300 + 64'(i), 1'b1, 2'd0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'd0, 64'h0, 1'b1, 2'd3);
        end

        // Drain VC1 and pop once more to provoke underflow.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'd0, 64'h0, 1'b1, 2'd1);
        end
        checkOutput("vc1Unf", W'(underflow), 64'd1);

        // Reset asynchronously in the middle of a write burst.
        applyStimulus(1'b1, 2'd1, 64'h411, 1'b0, 2'd1);
        applyStimulus(1'b1, 2'd1, 64'h422, 1'b0, 2'd1);
        produce = 1'b1;
        inVc    = 2'd1;
        flitIn  = 64'h433;
        #2;
        rst = 1'b1;
        #1;
        clearModel();
        checkStatus();
        checkOutput("rstEmpty", W'(empty), 64'hF);
        @(posedge clk);
        #1;
        produce = 1'b0;
        rst     = 1'b0;
        checkStatus();

        // Almost-full threshold on VC2.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 2'd2, 64'h600 + 64'(i), 1'b0, 2'd2);
        end
        checkOutput("afOn", W'(almostFull[2]), 64'd1);
        applyStimulus(1'b0, 2'd0, 64'h0, 1'b1, 2'd2);
        checkOutput("afOff", W'(almostFull[2]), 64'd0);

        // Random mixed traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), vc_idx_t'($urandom_range(0, NVC - 1)),
                          {32'($urandom), 32'($urandom)},
                          1'($urandom_range(0, 1)), vc_idx_t'($urandom_range(0, NVC - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vc_buffer.md
VC_BUFFER -- requirements
Module: vc_buffer

Interface
REQ-001 SHALL have parameter BUFFER_WIDTH, default 64, flit width in bits.
REQ-002 SHALL have parameter BUFFER_DEPTH_LOG, default 3, log2 of per-VC depth; BUFFER_DEPTH = 2**BUFFER_DEPTH_LOG.
REQ-003 SHALL have parameter NUM_VC, default 4, number of virtual channels; VC_LOG = max(1, clog2(NUM_VC)).
REQ-004 SHALL have parameter ALMOST_FULL_TH, default BUFFER_DEPTH-2, count at or above which almost_full asserts.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in  input  BUFFER_WIDTH  write flit.
REQ-008 in_vc  input  VC_LOG  target VC of write.
REQ-009 produce  input  1  write request.
REQ-010 rd_vc  input  VC_LOG  VC selected for read/out.
REQ-011 consume  input  1  pop head of rd_vc.
REQ-012 out  output  BUFFER_WIDTH  show-ahead head flit of rd_vc.
REQ-013 full, empty, almost_full  output  NUM_VC each  per-VC status vectors.
REQ-014 usedw  output  NUM_VC*(BUFFER_DEPTH_LOG+1)  per-VC occupancy, VC0 in LSBs.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Each VC SHALL be an independent FIFO of exactly BUFFER_DEPTH usable entries (no sacrificed slot).
REQ-017 Write accepted iff produce && !full[in_vc]; flit stored at tail of in_vc, tail advances, visible at out one cycle later.
REQ-018 Pop accepted iff consume && !empty[rd_vc]; head of rd_vc advances; out combinationally shows new head next cycle (zero-latency show-ahead).
REQ-019 out SHALL equal head entry of rd_vc whenever !empty[rd_vc]; value when empty is don't-care but stable (no X).
REQ-020 Pointers SHALL be BUFFER_DEPTH_LOG bits and wrap naturally from BUFFER_DEPTH-1 to 0.
REQ-021 Per-VC count SHALL be BUFFER_DEPTH_LOG+1 bits: +1 on accepted write only, -1 on accepted pop only, unchanged on both or neither.
REQ-022 full[v] = (count==BUFFER_DEPTH); empty[v] = (count==0); almost_full[v] = (count>=ALMOST_FULL_TH); all derived from registered count.
REQ-023 Simultaneous write and pop on same VC SHALL both succeed when not full and not empty; write to a full VC is rejected even if popped same cycle.
REQ-024 Simultaneous write and pop on different VCs SHALL be fully independent.
REQ-025 Rejected write SHALL set overflow; rejected pop SHALL set underflow; both stay set until reset; no pointer/count/storage change.
REQ-026 in_vc or rd_vc >= NUM_VC SHALL be treated as rejected write/pop respectively and set the matching error flag.

Reset
REQ-027 rst assertion SHALL asynchronously clear all pointers, counts, overflow, underflow: empty all 1, full and almost_full all 0, usedw 0.
REQ-028 Storage array SHALL NOT be reset; reset mid-operation discards all in-flight flits.
REQ-029 First accepted write SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package router_buffer_pkg SHALL hold flit typedef, VC index typedef and default depth/width constants.
REQ-031 Per-VC pointer/count/flag logic SHALL be sub-module vc_fifo_ctrl, instantiated NUM_VC times via generate; storage one flat array indexed {vc, ptr}.

Verification
REQ-032 Reset then write 0x11,0x22,0x33 to VC1 -> out with rd_vc=1 shows 0x11, usedw[VC1]=3, empty=4'b1101.
REQ-033 Fill VC2 with 8 flits, 9th write -> full[2]=1, overflow=1, usedw[VC2]=8, 9th flit never appears at out.
REQ-034 VC0 holding 1 flit, produce+consume same cycle for 20 cycles -> usedw[VC0] constant 1, out sequence in order across pointer wrap.
REQ-035 Write VC3 while popping VC0 each cycle -> counts change independently, no flit crosses VCs.
REQ-036 consume on empty VC1 -> underflow=1, head unchanged; assert rst mid-burst -> all empty within same cycle, flags cleared.
REQ-037 Count reaches 6 on any VC (defaults) -> almost_full asserts; pop to 5 -> deasserts next cycle.
